// File: rtl/simon_seq_gen.sv
// Simon colour sequence generator: latches a game seed and replays the current round's
// colours from a Galois LFSR over a valid/ready stream.
module simon_seq_gen #(
   parameter int unsigned  MAX_LEN  = 32,
   parameter logic [31:0]  POLY     = 32'h80200003,
   parameter logic [31:0]  ZERO_SUB = 32'h00000001,
   localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      seed,
   input  logic             load,
   input  logic             replay,
   input  logic             next_round,
   input  logic             color_ready,
   output logic [1:0]       color,
   output logic             color_valid,
   output logic             color_last,
   output logic             seq_done,
   output logic [LEN_W-1:0] round_len,
   output logic             max_reached
);

   typedef enum logic {
      StIdle,
      StEmit
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        seed_q, seed_d;
   logic [31:0]        lfsr_q, lfsr_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               done_q, done_d;
   logic               max_q, max_d;
   logic [31:0]        lfsr_step;
   logic               emit_last;

   assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
   assign emit_last = (idx_q == len_q - LEN_W'(1));

   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      lfsr_d  = lfsr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      max_d   = max_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               // A zero seed would lock the LFSR at zero forever.
               seed_d = (seed == 32'h0) ? ZERO_SUB : seed;
               len_d  = LEN_W'(1);
               max_d  = 1'b0;
            end else if (replay) begin
               if (len_q != '0) begin
                  lfsr_d  = seed_q;
                  idx_d   = '0;
                  state_d = StEmit;
               end
            end else if (next_round) begin
               if (len_q < LEN_W'(MAX_LEN)) begin
                  len_d = len_q + LEN_W'(1);
               end else begin
                  max_d = 1'b1;
               end
            end
         end
         StEmit: begin
            if (color_ready) begin
               if (emit_last) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  lfsr_d = lfsr_step;
                  idx_d  = idx_q + LEN_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         seed_q  <= 32'h0;
         lfsr_q  <= 32'h0;
         idx_q   <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         max_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         lfsr_q  <= lfsr_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         done_q  <= done_d;
         max_q   <= max_d;
      end
   end

   assign color_valid = (state_q == StEmit);
   assign color       = color_valid ? lfsr_q[1:0] : 2'b00;
   assign color_last  = color_valid && emit_last;
   assign seq_done    = done_q;
   assign round_len   = len_q;
   assign max_reached = max_q;

endmodule

// File: tb/tb_simon_seq_gen.sv
// Bench for simon_seq_gen: directed scenarios plus randomized traffic against a
// sequence-level reference model.
module tb_simon_seq_gen;

   localparam int MaxLen = 4;
   localparam int LenW   = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [31:0]     seed;
   logic            load, replay, next_round, color_ready;
   logic [1:0]      color;
   logic            color_valid, color_last, seq_done, max_reached;
   logic [LenW-1:0] round_len;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   logic [31:0] m_seed;
   int          m_len;
   int          m_pos;
   bit          m_max, m_emit, m_done;

   simon_seq_gen #(.MAX_LEN(MaxLen)) dut (
      .clk         (clk),
      .reset       (reset),
      .seed        (seed),
      .load        (load),
      .replay      (replay),
      .next_round  (next_round),
      .color_ready (color_ready),
      .color       (color),
      .color_valid (color_valid),
      .color_last  (color_last),
      .seq_done    (seq_done),
      .round_len   (round_len),
      .max_reached (max_reached)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // k-th colour of the sequence produced from seed s.
   function automatic logic [1:0] col_at(input logic [31:0] s, input int k);
      logic [31:0] v = s;
      for (int i = 0; i < k; i++) v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
      return v[1:0];
   endfunction

   task automatic model_reset();
      m_seed = 32'h0; m_len = 0; m_pos = 0;
      m_max = 0; m_emit = 0; m_done = 0;
   endtask

   task automatic check_outputs();
      logic [1:0] ec;
      ec = m_emit ? col_at(m_seed, m_pos) : 2'b00;
      check("valid", 32'(color_valid), 32'(m_emit));
      check("color", 32'(color), 32'(ec));
      check("last", 32'(color_last), 32'(m_emit && (m_pos == m_len - 1)));
      check("seq_done", 32'(seq_done), 32'(m_done));
      check("round_len", 32'(round_len), 32'(m_len));
      check("max_reached", 32'(max_reached), 32'(m_max));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check at the negedge.
   task automatic step(input bit ld, input logic [31:0] sd, input bit rp, input bit nr,
                       input bit rdy);
      bit nd;
      load = ld; seed = sd; replay = rp; next_round = nr; color_ready = rdy;
      @(posedge clk);
      nd = 0;
      if (m_emit) begin
         if (rdy) begin
            if (m_pos == m_len - 1) begin
               m_emit = 0;
               nd = 1;
            end else begin
               m_pos++;
            end
         end
      end else if (ld) begin
         m_seed = (sd == 32'h0) ? 32'h1 : sd;
         m_len  = 1;
         m_max  = 0;
      end else if (rp) begin
         if (m_len != 0) begin
            m_emit = 1;
            m_pos  = 0;
         end
      end else if (nr) begin
         if (m_len < MaxLen) m_len++;
         else m_max = 1;
      end
      m_done = nd;
      @(negedge clk);
      check_outputs();
   endtask

   // Asynchronous reset asserted between edges; entered and left at a negedge.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_valid", 32'(color_valid), 32'h0);
      check("rst_color", 32'(color), 32'h0);
      check("rst_last", 32'(color_last), 32'h0);
      check("rst_done", 32'(seq_done), 32'h0);
      check("rst_len", 32'(round_len), 32'h0);
      check("rst_max", 32'(max_reached), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      check_outputs();
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * MaxLen + 2 && color_valid; i++) step(0, 32'h0, 0, 0, 1);
      check("drain_idle", 32'(color_valid), 32'h0);
   endtask

   task automatic start_len4();
      step(1, 32'h1, 0, 0, 0);
      repeat (3) step(0, 32'h0, 0, 1, 0);
      step(0, 32'h0, 1, 0, 0);
   endtask

   initial begin
      logic [1:0] t3_exp [4];
      t3_exp = '{2'd1, 2'd3, 2'd2, 2'd1};
      reset = 1'b0; seed = 32'h0; load = 0; replay = 0; next_round = 0; color_ready = 0;
      model_reset();
      @(negedge clk);
      check_outputs();
      reset = 1'b1;

      // Replay before any load is ignored.
      step(0, 32'h0, 1, 0, 1);
      check("t1_noreplay", 32'(color_valid), 32'h0);

      // Single-colour round.
      step(1, 32'h1, 0, 0, 0);
      step(0, 32'h0, 1, 0, 1);
      check("t2_color", 32'(color), 32'h1);
      check("t2_last", 32'(color_last), 32'h1);
      step(0, 32'h0, 0, 0, 1);
      check("t2_done", 32'(seq_done), 32'h1);
      step(0, 32'h0, 0, 0, 1);
      check("t2_len", 32'(round_len), 32'h1);

      // Four colours back to back.
      start_len4();
      for (int i = 0; i < 4; i++) begin
         check("t3_color", 32'(color), 32'(t3_exp[i]));
         check("t3_last", 32'(color_last), 32'(i == 3));
         step(0, 32'h0, 0, 0, 1);
      end
      check("t3_done", 32'(seq_done), 32'h1);

      // Backpressure on the second colour.
      start_len4();
      step(0, 32'h0, 0, 0, 1);
      repeat (3) begin
         step(0, 32'h0, 0, 0, 0);
         check("t4_hold", 32'(color), 32'h3);
      end
      for (int i = 1; i < 4; i++) begin
         check("t4_color", 32'(color), 32'(t3_exp[i]));
         step(0, 32'h0, 0, 0, 1);
      end
      check("t4_done", 32'(seq_done), 32'h1);

      // Zero seed substitution; load ignored mid-stream.
      step(1, 32'h0, 0, 0, 0);
      step(0, 32'h0, 0, 1, 0);
      step(0, 32'h0, 1, 0, 0);
      check("t5_color", 32'(color), 32'h1);
      step(1, 32'hdeadbeef, 0, 0, 0);
      check("t5_len", 32'(round_len), 32'h2);
      drain();
      step(0, 32'h0, 1, 0, 0);
      check("t5_again", 32'(color), 32'h1);
      drain();

      // Saturation at MAX_LEN.
      step(1, 32'h5, 0, 0, 0);
      repeat (5) step(0, 32'h0, 0, 1, 0);
      check("t6_len", 32'(round_len), 32'(MaxLen));
      check("t6_max", 32'(max_reached), 32'h1);
      step(1, 32'h5, 0, 0, 0);
      check("t6_clr_len", 32'(round_len), 32'h1);
      check("t6_clr_max", 32'(max_reached), 32'h0);

      // Reset mid-stream, then replay is ignored.
      start_len4();
      step(0, 32'h0, 0, 0, 1);
      do_reset();
      step(0, 32'h0, 1, 0, 1);
      check("t1_after_rst", 32'(color_valid), 32'h0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] sd;
         sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 499) == 0) do_reset();
         step($urandom_range(0, 99) < 5, sd, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 70);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
